// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B, one bit per cycle LSB first, with borrow out.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             bo,
    output logic             busy,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             done,
    output logic             ovf
`else
    output logic             done
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [CW-1:0] r_cnt;
    logic r_br, w_d, w_br_next, w_last, w_accept;
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign w_accept  = start && (r_state != RUN);
    always_comb begin
        w_next = r_state;
        busy   = r_state == RUN;
        done   = r_state == DONE;
        w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // operand sign bits are kept because r_a/r_b are consumed by shifting
    logic r_asgn, r_bsgn;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asgn <= 1'b0;
            r_bsgn <= 1'b0;
            ovf    <= 1'b0;
        end else if (w_accept) begin
            r_asgn <= A[WIDTH-1];
            r_bsgn <= B[WIDTH-1];
        end else if (r_state == RUN && w_last) begin
            ovf <= (r_asgn != r_bsgn) && (w_d != r_asgn);
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
            out   <= '0;
            bo    <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_cnt <= '0;
            r_br  <= 1'b0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CW'(1);
            r_res <= {w_d, r_res[WIDTH-1:1]};
            if (w_last) begin
                out <= {w_d, r_res[WIDTH-1:1]};
                bo  <= w_br_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor (WIDTH=4)
// against a cycle-count/arithmetic model; honours SERIAL_SUBTRACTOR_OVF_EN.
module tb_serial_subtractor;
    localparam int W = 4;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] A = '0, B = '0, out;
    logic bo, busy, done;
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf;
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .out(out), .bo(bo), .busy(busy), .done(done), .ovf(ovf));
`else
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .out(out), .bo(bo), .busy(busy), .done(done));
`endif
    // model: remaining run cycles, pending operands, and the registered results
    int m_rem = 0;
    bit m_valid = 0, m_done = 0, m_bo = 0, m_ovf = 0;
    logic [W-1:0] m_out = '0, pa = '0, pb = '0;
    always @(posedge clk) begin
        logic [W:0] diff;
        m_valid = 1;
        if (rst) begin
            m_rem = 0; m_done = 0; m_out = '0; m_bo = 0; m_ovf = 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                diff   = {1'b0, pa} - {1'b0, pb};
                m_out  = diff[W-1:0];
                m_bo   = diff[W];
                m_ovf  = (pa[W-1] != pb[W-1]) && (diff[W-1] != pa[W-1]);
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_rem = W; pa = A; pb = B;
            end
        end
    end
    always @(negedge clk) begin
        if (m_valid) begin
            n_vec++;
            if ({busy, done, bo, out} !== {m_rem > 0, m_done, m_bo, m_out}) begin
                n_err++;
                $display("FAIL cycle busy/done/bo/out got %b/%b/%b/%0d want %b/%b/%b/%0d at %0t",
                    busy, done, bo, out, m_rem > 0, m_done, m_bo, m_out, $time);
            end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            n_vec++;
            if (ovf !== m_ovf) begin
                n_err++;
                $display("FAIL cycle ovf got %b want %b at %0t", ovf, m_ovf, $time);
            end
`endif
        end
    end
    task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask
    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (done !== 1'b1 && t < 3 * W);
        chk("done_timeout", {5'b0, done}, 6'd1);
    endtask
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {5'b0, busy}, 6'd1);
    endtask
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eo, input logic eb);
        launch(a, b);
        wait_done();
        chk("out_literal", {2'b0, out}, {2'b0, eo});
        chk("bo_literal", {5'b0, bo}, {5'b0, eb});
    endtask
    initial begin
        logic [W-1:0] a, b;
        logic [W:0] d;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, done, bo, out}, '0);
        rst = 1'b0;
        op(4'd9, 4'd3, 4'd6, 1'b0);
        op(4'd3, 4'd9, 4'd10, 1'b1);
        op(4'd0, 4'd15, 4'd1, 1'b1);
        op(4'd5, 4'd5, 4'd0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        op(4'd7, 4'd15, 4'd8, 1'b1);
        chk("ovf_set", {5'b0, ovf}, 6'd1);
        op(4'd7, 4'd1, 4'd6, 1'b0);
        chk("ovf_clear", {5'b0, ovf}, 6'd0);
`endif
        launch(4'd12, 4'd4);
        start = 1'b1; A = 4'd1; B = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("ignore_start_out", {2'b0, out}, 6'd8);
        chk("ignore_start_bo", {5'b0, bo}, 6'd0);
        start = 1'b1; A = 4'd2; B = 4'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {busy, done}, 6'b10);
        wait_done();
        chk("b2b_out", {bo, out}, {1'b0, 5'b11011});
        launch(4'd9, 4'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", {busy, done, bo, out}, '0);
        op(4'd7, 4'd2, 4'd5, 1'b0);
        for (int i = 0; i < 256; i++) begin
            a = W'($urandom); b = W'($urandom);
            d = {1'b0, a} - {1'b0, b};
            launch(a, b);
            wait_done();
            chk("rand_result", {1'b0, bo, out}, {1'b0, d});
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
